// File: rtl/spi_reg_responder_pkg.sv
// rtl/spi_reg_responder_pkg.sv - shared FSM states, header layout and register-file geometry
package spi_reg_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA
    } state_t;

    localparam int HDR_RW    = 7;
    localparam int HDR_BURST = 6;
    localparam int ADDR_W    = 6;
    localparam int REG_DEPTH = 64;

endpackage

// File: rtl/spi_resp_sync.sv
// rtl/spi_resp_sync.sv - multi-flop synchronizer with rise/fall detection on the synchronized level
module spi_resp_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 responder onto a 64x8 register file; SPI_RESP_BURST_EN enables burst auto-increment
module spi_reg_responder
    import spi_reg_responder_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [7:0]  RESET_STATUS = 8'h0F
) (
    input  logic              CLK_48MHZ,
    input  logic              BUF2_PBRST_T9,
    input  logic              SCLK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [7:0]        status_i,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [7:0]        loc_rdata,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    logic w_sclk_rise, w_sclk_fall, w_ss_q, w_ss_fall, w_mosi_q;

    spi_resp_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(CLK_48MHZ), .rst_n(BUF2_PBRST_T9), .i_d(SCLK),
        .o_q(), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_resp_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(CLK_48MHZ), .rst_n(BUF2_PBRST_T9), .i_d(SS),
        .o_q(w_ss_q), .o_rise(), .o_fall(w_ss_fall)
    );
    spi_resp_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(CLK_48MHZ), .rst_n(BUF2_PBRST_T9), .i_d(MOSI),
        .o_q(w_mosi_q), .o_rise(), .o_fall()
    );

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_bit_cnt;
    logic [6:0]          r_rx_shift;
    logic [7:0]          r_tx_shift;
    logic                r_miso;
    logic                r_rw;
    logic                r_dead;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_mem [REG_DEPTH];
    logic                r_wr_valid;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data;

    logic [7:0]          w_status;
    logic [7:0]          w_byte;
    logic                w_active;
    logic                w_byte_end;
    logic                w_advance;
    logic                w_next_dead;
    logic [ADDR_W-1:0]   w_next_addr;

    assign w_status    = BUF2_PBRST_T9 ? status_i : RESET_STATUS;
    assign w_byte      = {r_rx_shift, w_mosi_q};
    assign w_active    = !w_ss_q && (r_state != ST_IDLE);
    assign w_byte_end  = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_next_addr = r_addr + 1'b1;
    assign w_next_dead = r_dead | ~w_advance;

`ifdef SPI_RESP_BURST_EN
    logic r_burst;

    always_ff @(posedge CLK_48MHZ or negedge BUF2_PBRST_T9) begin
        if (!BUF2_PBRST_T9) begin
            r_burst <= 1'b0;
        end else if (w_byte_end && r_state == ST_HEADER) begin
            r_burst <= w_byte[HDR_BURST];
        end
    end

    assign w_advance = r_burst;
`else
    assign w_advance = 1'b0;
`endif

    always_ff @(posedge CLK_48MHZ or negedge BUF2_PBRST_T9) begin
        if (!BUF2_PBRST_T9) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_ss_q) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_ss_fall) w_state_nxt = ST_HEADER;
                ST_HEADER: if (w_byte_end) w_state_nxt = ST_DATA;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // Once a non-burst transfer has used its one data byte (r_dead), reads shift zeros and writes are dropped.
    always_ff @(posedge CLK_48MHZ or negedge BUF2_PBRST_T9) begin
        if (!BUF2_PBRST_T9) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_miso     <= 1'b0;
            r_rw       <= 1'b0;
            r_dead     <= 1'b0;
            r_addr     <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            r_wr_valid <= 1'b0;
            if (w_ss_q) begin
                r_miso     <= 1'b0;
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
                r_tx_shift <= '0;
            end else if (r_state == ST_IDLE) begin
                if (w_ss_fall) begin
                    r_miso     <= w_status[7];
                    r_tx_shift <= {w_status[6:0], 1'b0};
                    r_bit_cnt  <= '0;
                    r_rx_shift <= '0;
                    r_dead     <= 1'b0;
                end
            end else begin
                if (w_sclk_fall) begin
                    r_miso     <= r_tx_shift[7];
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
                if (w_sclk_rise) begin
                    r_rx_shift <= w_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                if (w_byte_end) begin
                    if (r_state == ST_HEADER) begin
                        r_rw   <= w_byte[HDR_RW];
                        r_addr <= w_byte[ADDR_W-1:0];
                        if (w_byte[HDR_RW]) begin
                            r_tx_shift <= r_mem[w_byte[ADDR_W-1:0]];
                        end
                    end else begin
                        if (!r_rw && !r_dead) begin
                            r_mem[r_addr] <= w_byte;
                            r_wr_valid    <= 1'b1;
                            r_wr_addr     <= r_addr;
                            r_wr_data     <= w_byte;
                        end
                        r_dead <= w_next_dead;
                        if (w_advance) begin
                            r_addr <= w_next_addr;
                        end
                        if (r_rw) begin
                            r_tx_shift <= w_next_dead ? 8'h00 : r_mem[w_next_addr];
                        end
                    end
                end
            end
        end
    end

    assign MISO      = r_miso & ~SS;
    assign loc_rdata = r_mem[loc_addr];
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb/tb_spi_reg_responder.sv - randomized self-checking bench for spi_reg_responder against a register-file model
module tb_spi_reg_responder;

    logic       CLK_48MHZ = 1'b0;
    logic       BUF2_PBRST_T9;
    logic       SCLK;
    logic       SS;
    logic       MOSI;
    logic       MISO;
    logic [7:0] status_i;
    logic [5:0] loc_addr;
    logic [7:0] loc_rdata;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mdl_mem [64];
    logic [7:0]  tx_data [$];
    logic [13:0] wr_log  [$];

`ifdef SPI_RESP_BURST_EN
    localparam bit BURST_MODEL = 1'b1;
`else
    localparam bit BURST_MODEL = 1'b0;
`endif

    spi_reg_responder dut (
        .CLK_48MHZ    (CLK_48MHZ),
        .BUF2_PBRST_T9(BUF2_PBRST_T9),
        .SCLK         (SCLK),
        .SS           (SS),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .status_i     (status_i),
        .loc_addr     (loc_addr),
        .loc_rdata    (loc_rdata),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    always #10 CLK_48MHZ = ~CLK_48MHZ;

    always @(negedge CLK_48MHZ) begin
        if (wr_valid === 1'b1) wr_log.push_back({wr_addr, wr_data});
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK_48MHZ);
    endtask

    task automatic ss_begin;
        SS = 1'b0;
        wait_clk(4);
    endtask

    task automatic ss_end;
        wait_clk(4);
        SS = 1'b1;
        wait_clk(10);
    endtask

    // SCLK runs at CLK/8: four clock cycles per half period.
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            wait_clk(4);
            rx[i] = MISO;
            SCLK = 1'b1;
            wait_clk(4);
            SCLK = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] tx, input int n);
        for (int i = 0; i < n; i++) begin
            MOSI = tx[7-i];
            wait_clk(4);
            SCLK = 1'b1;
            wait_clk(4);
            SCLK = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 64; a++) begin
            loc_addr = 6'(a);
            #1;
            n_checks++;
            if (loc_rdata !== mdl_mem[a]) begin
                n_errors++;
                $display("FAIL %s regfile[%0d]: got %h want %h", tag, a, loc_rdata, mdl_mem[a]);
            end
        end
    endtask

    task automatic run_txn(input logic [7:0] hdr, input string tag);
        logic [7:0]  rx_hdr;
        logic [7:0]  rx;
        logic [7:0]  got [$];
        logic [7:0]  exp_rd [$];
        logic [13:0] exp_wr [$];
        logic [7:0]  exp_hdr;
        int          a;
        bit          ok;
        exp_hdr = status_i;
        for (int k = 0; k < tx_data.size(); k++) begin
            ok = (k == 0) || (BURST_MODEL && hdr[6]);
            a  = (int'(hdr[5:0]) + k) % 64;
            if (hdr[7]) begin
                exp_rd.push_back(ok ? mdl_mem[a] : 8'h00);
            end else if (ok) begin
                mdl_mem[a] = tx_data[k];
                exp_wr.push_back({6'(a), tx_data[k]});
            end
        end
        wr_log.delete();
        ss_begin();
        xfer(hdr, rx_hdr);
        for (int k = 0; k < tx_data.size(); k++) begin
            xfer(tx_data[k], rx);
            got.push_back(rx);
        end
        ss_end();
        n_checks++;
        if (rx_hdr !== exp_hdr) begin
            n_errors++;
            $display("FAIL %s header_miso: got %h want %h", tag, rx_hdr, exp_hdr);
        end
        if (hdr[7]) begin
            for (int k = 0; k < exp_rd.size(); k++) begin
                n_checks++;
                if (got[k] !== exp_rd[k]) begin
                    n_errors++;
                    $display("FAIL %s read_byte%0d: got %h want %h", tag, k, got[k], exp_rd[k]);
                end
            end
        end
        n_checks++;
        if (wr_log.size() != exp_wr.size()) begin
            n_errors++;
            $display("FAIL %s wr_pulse_count: got %0d want %0d", tag, wr_log.size(), exp_wr.size());
        end else begin
            for (int k = 0; k < exp_wr.size(); k++) begin
                n_checks++;
                if (wr_log[k] !== exp_wr[k]) begin
                    n_errors++;
                    $display("FAIL %s wr_pulse%0d addr/data: got %h want %h", tag, k, wr_log[k], exp_wr[k]);
                end
            end
        end
        n_checks++;
        if (MISO !== 1'b0) begin
            n_errors++;
            $display("FAIL %s miso_idle: got %b want 0", tag, MISO);
        end
        tx_data.delete();
    endtask

    task automatic test_reset;
        BUF2_PBRST_T9 = 1'b0;
        SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        status_i = 8'h00; loc_addr = 6'd0;
        foreach (mdl_mem[i]) mdl_mem[i] = 8'h00;
        wait_clk(3);
        n_checks++;
        if (MISO !== 1'b0) begin n_errors++; $display("FAIL reset miso: got %b want 0", MISO); end
        n_checks++;
        if (wr_valid !== 1'b0) begin n_errors++; $display("FAIL reset wr_valid: got %b want 0", wr_valid); end
        n_checks++;
        if (wr_addr !== 6'd0) begin n_errors++; $display("FAIL reset wr_addr: got %h want 0", wr_addr); end
        n_checks++;
        if (wr_data !== 8'd0) begin n_errors++; $display("FAIL reset wr_data: got %h want 0", wr_data); end
        check_regs("reset");
        BUF2_PBRST_T9 = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_status_readback;
        status_i = 8'hA5;
        tx_data.push_back(8'h00);
        run_txn(8'h80, "status_readback");
    endtask

    task automatic test_write_read;
        status_i = 8'h3A;
        tx_data.push_back(8'h3C);
        run_txn(8'h05, "write5");
        tx_data.push_back(8'h00);
        run_txn(8'h85, "read5");
        loc_addr = 6'd5;
        #1;
        n_checks++;
        if (loc_rdata !== 8'h3C) begin n_errors++; $display("FAIL loc_rdata5: got %h want 3c", loc_rdata); end
    endtask

    task automatic test_burst_wrap;
        status_i = 8'h5C;
        tx_data.push_back(8'h11);
        tx_data.push_back(8'h22);
        run_txn(8'h7F, "burst_wr");
        check_regs("burst_wrap");
        tx_data.push_back(8'h00);
        tx_data.push_back(8'h00);
        run_txn(8'hFF, "burst_rd");
    endtask

    task automatic test_abort;
        logic [7:0] rx;
        status_i = 8'h21;
        tx_data.push_back(8'h5A);
        run_txn(8'h02, "abort_setup");
        for (int mode = 0; mode < 2; mode++) begin
            wr_log.delete();
            ss_begin();
            xfer(8'h02, rx);
            if (mode == 0) begin
                send_bits(8'hC3, 5);
                wait_clk(4);
                SS = 1'b1;
            end else begin
                send_bits(8'hC3, 7);
                MOSI = 1'b1;
                wait_clk(4);
                SS = 1'b1;
                SCLK = 1'b1;
                wait_clk(4);
                SCLK = 1'b0;
            end
            wait_clk(10);
            n_checks++;
            if (wr_log.size() != 0) begin
                n_errors++;
                $display("FAIL abort%0d wr_pulse_count: got %0d want 0", mode, wr_log.size());
            end
            loc_addr = 6'd2;
            #1;
            n_checks++;
            if (loc_rdata !== 8'h5A) begin
                n_errors++;
                $display("FAIL abort%0d regfile2: got %h want 5a", mode, loc_rdata);
            end
        end
        tx_data.push_back(8'h00);
        run_txn(8'h82, "after_abort");
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] rx;
        status_i = 8'h77;
        tx_data.push_back(8'hFF);
        run_txn(8'h00, "prefill0");
        tx_data.push_back(8'hFF);
        run_txn(8'h01, "prefill1");
        ss_begin();
        xfer(8'hC0, rx);
        send_bits(8'h00, 3);
        wait_clk(4);
        n_checks++;
        if (MISO !== 1'b1) begin n_errors++; $display("FAIL midread miso_before_reset: got %b want 1", MISO); end
        BUF2_PBRST_T9 = 1'b0;
        #1;
        n_checks++;
        if (MISO !== 1'b0) begin n_errors++; $display("FAIL midread miso_in_reset: got %b want 0", MISO); end
        SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        foreach (mdl_mem[i]) mdl_mem[i] = 8'h00;
        wait_clk(2);
        check_regs("midread_reset");
        BUF2_PBRST_T9 = 1'b1;
        wait_clk(4);
        status_i = 8'($urandom);
        tx_data.push_back(8'h00);
        run_txn(8'h80, "post_reset_read");
        tx_data.push_back(8'h96);
        run_txn(8'h0A, "post_reset_write");
        tx_data.push_back(8'h00);
        run_txn(8'h8A, "post_reset_readback");
    endtask

    task automatic test_random_min_spacing;
        int n;
        for (int i = 0; i < 64; i++) begin
            status_i = 8'($urandom);
            tx_data.push_back(8'($urandom));
            run_txn({2'b00, 6'(i)}, "rand_wr");
        end
        for (int i = 0; i < 64; i++) begin
            status_i = 8'($urandom);
            tx_data.push_back(8'($urandom));
            run_txn({2'b10, 6'(i)}, "rand_rd");
        end
        for (int t = 0; t < 8; t++) begin
            status_i = 8'($urandom);
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) tx_data.push_back(8'($urandom));
            run_txn(8'($urandom), "rand_mixed");
        end
        check_regs("random_final");
    endtask

    initial begin
        test_reset();
        test_status_readback();
        test_write_read();
        test_burst_wrap();
        test_abort();
        test_reset_mid_read();
        test_random_min_spacing();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
